// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared definitions for the front-end pipeline controller: state encoding,
// the control-output bundle, the default counter width and a sizing helper.

`ifndef FPC_DEFAULT_CNT_W
`define FPC_DEFAULT_CNT_W 32
`endif

package fetch_pipe_ctrl_pkg;

  // Default width of the performance counters.
  localparam int DEFAULT_CNT_W = `FPC_DEFAULT_CNT_W;

  // Width of the flush-window down-counter; covers windows of up to 15 cycles.
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Pipeline-register controls produced every cycle.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic flush_ifid;
    logic flush_idex;
    logic iabort;
  } ctrl_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int width_for(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones instead of
// wrapping so long-running performance counts never read back as small values.

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on i_inc, stop at all-ones; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent simulation races.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Front-end pipeline controller. Decodes I-cache miss, load-use and branch
// mispredict into stall/flush controls for the IF/ID and ID/EX registers,
// sequences the miss wait (with timeout) and the post-redirect flush window,
// and keeps saturating stall/flush performance counters.
// Control outputs are a combinational decode of state and inputs so the
// pipeline registers react in the same cycle; they are forced low in reset.

module fetch_pipe_ctrl
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IMISS,
  input  logic             IREADY,
  input  logic             LOAD_USE,
  input  logic             MISPREDICT,
  output logic             STALL_IF,
  output logic             STALL_ID,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             IABORT,
  output logic             ERR_TIMEOUT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int TMO_W = width_for(MISS_TIMEOUT);

  // Flush counter reload: the accepting cycle is the first of the window.
  localparam logic [FLUSH_CNT_W-1:0] FC_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(MISS_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]       TMO_MAX   = TMO_W'(MISS_TIMEOUT);

  state_t                   r_state;
  logic [FLUSH_CNT_W-1:0]   r_flush_cnt;
  logic [TMO_W-1:0]         r_tmo_cnt;
  logic                     r_err;

  state_t                   w_state_next;
  logic [FLUSH_CNT_W-1:0]   w_fcnt_next;
  ctrl_t                    w_ctrl;
  logic                     w_flush_evt;

  // Next-state and Mealy control decode; mispredict outranks load-use outranks miss.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_ctrl       = '0;
    w_state_next = r_state;
    w_fcnt_next  = r_flush_cnt;
    w_flush_evt  = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (MISPREDICT) begin
          w_ctrl.flush_ifid = 1'b1;
          w_ctrl.flush_idex = 1'b1;
          w_flush_evt       = 1'b1;
          w_fcnt_next       = FC_RELOAD;
          w_state_next      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (LOAD_USE) begin
          // Hold IF/ID one cycle and feed a bubble into ID/EX.
          w_ctrl.stall_if   = 1'b1;
          w_ctrl.flush_idex = 1'b1;
        end else if (IMISS) begin
          w_ctrl.stall_if   = 1'b1;
          w_ctrl.stall_id   = 1'b1;
          w_state_next      = ST_MISS;
        end
      end

      ST_MISS: begin
        if (MISPREDICT) begin
          // Redirect beats the refill: cancel it and drop the stalls so flush wins.
          w_ctrl.iabort     = 1'b1;
          w_ctrl.flush_ifid = 1'b1;
          w_ctrl.flush_idex = 1'b1;
          w_flush_evt       = 1'b1;
          w_fcnt_next       = FC_RELOAD;
          w_state_next      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
          // Load-use needs no handling here: the full stall already covers it.
          w_ctrl.stall_if = 1'b1;
          w_ctrl.stall_id = 1'b1;
          if (IREADY) begin
            w_state_next = ST_RUN;
          end
        end
      end

      ST_FLUSH: begin
        w_ctrl.flush_ifid = 1'b1;
        w_ctrl.flush_idex = 1'b1;
        if (MISPREDICT) begin
          w_flush_evt = 1'b1;
          w_fcnt_next = FC_RELOAD;
        end else if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
          w_state_next = ST_RUN;
        end else begin
          w_fcnt_next = r_flush_cnt - FLUSH_CNT_W'(1);
        end
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State and flush-window counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_fcnt_next;
    end
  end

  // Miss-wait timer: idle at zero outside the wait, counts up inside it and
  // parks at MISS_TIMEOUT so a very long refill cannot wrap it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_MISS) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_MAX) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Sticky timeout flag, raised as the wait completes its MISS_TIMEOUT-th cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_MISS) && (r_tmo_cnt == TMO_LAST)) begin
      r_err <= 1'b1;
    end
  end

  // Controls are held low for as long as reset is asserted.
  assign STALL_IF    = RESET & w_ctrl.stall_if;
  assign STALL_ID    = RESET & w_ctrl.stall_id;
  assign FLUSH_IFID  = RESET & w_ctrl.flush_ifid;
  assign FLUSH_IDEX  = RESET & w_ctrl.flush_idex;
  assign IABORT      = RESET & w_ctrl.iabort;
  assign ERR_TIMEOUT = r_err;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_inc   (STALL_IF),
    .i_clear (1'b0),
    .o_count (STALL_CNT)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_inc   (RESET & w_flush_evt),
    .i_clear (1'b0),
    .o_count (FLUSH_CNT)
  );

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl with FLUSH_CYCLES=3, MISS_TIMEOUT=4, CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Control vector order: {STALL_IF,STALL_ID,FLUSH_IFID,FLUSH_IDEX,IABORT,ERR_TIMEOUT}.

module tb_fetch_pipe_ctrl;

  localparam int FLUSH_CYCLES = 3;
  localparam int MISS_TIMEOUT = 4;
  localparam int CNT_W        = 4;

  logic             CLK;
  logic             RESET;
  logic             IMISS;
  logic             IREADY;
  logic             LOAD_USE;
  logic             MISPREDICT;
  logic             STALL_IF;
  logic             STALL_ID;
  logic             FLUSH_IFID;
  logic             FLUSH_IDEX;
  logic             IABORT;
  logic             ERR_TIMEOUT;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;
  logic [5:0]       ctrl;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pipe_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MISS_TIMEOUT (MISS_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IMISS       (IMISS),
    .IREADY      (IREADY),
    .LOAD_USE    (LOAD_USE),
    .MISPREDICT  (MISPREDICT),
    .STALL_IF    (STALL_IF),
    .STALL_ID    (STALL_ID),
    .FLUSH_IFID  (FLUSH_IFID),
    .FLUSH_IDEX  (FLUSH_IDEX),
    .IABORT      (IABORT),
    .ERR_TIMEOUT (ERR_TIMEOUT),
    .STALL_CNT   (STALL_CNT),
    .FLUSH_CNT   (FLUSH_CNT)
  );

  assign ctrl = {STALL_IF, STALL_ID, FLUSH_IFID, FLUSH_IDEX, IABORT, ERR_TIMEOUT};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational controls mid-cycle,
  // and return just after the next rising edge.
  task automatic cyc(input string tag, input logic imiss, input logic iready,
                     input logic lu, input logic mp, input logic [5:0] exp);
    IMISS      = imiss;
    IREADY     = iready;
    LOAD_USE   = lu;
    MISPREDICT = mp;
    @(negedge CLK);
    check(tag, 32'(ctrl), 32'(exp));
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    IMISS = 1'b0; IREADY = 1'b0; LOAD_USE = 1'b0; MISPREDICT = 1'b0;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b0;
    IMISS = 1'b1; IREADY = 1'b0; LOAD_USE = 1'b1; MISPREDICT = 1'b1;

    // Controls must stay low while in reset even with every request active.
    @(negedge CLK);
    check("in_reset_ctrl", 32'(ctrl), 32'h0);
    apply_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) cyc($sformatf("idle%0d", i), 0, 0, 0, 0, 6'b000000);
    check("idle_stall_cnt", 32'(STALL_CNT), 32'd0);
    check("idle_flush_cnt", 32'(FLUSH_CNT), 32'd0);

    // Single-cycle load-use bubble.
    apply_reset();
    cyc("lu", 0, 0, 1, 0, 6'b100100);
    check("lu_stall_cnt", 32'(STALL_CNT), 32'd1);
    cyc("lu_after", 0, 0, 0, 0, 6'b000000);
    check("lu_stall_cnt_hold", 32'(STALL_CNT), 32'd1);

    // Miss, refill 5 cycles later; load-use during the wait changes nothing.
    // With MISS_TIMEOUT=4 the sticky error appears in the 5th wait cycle.
    apply_reset();
    cyc("miss0", 1, 0, 0, 0, 6'b110000);
    cyc("miss1", 0, 0, 0, 0, 6'b110000);
    cyc("miss2_lu", 0, 0, 1, 0, 6'b110000);
    cyc("miss3", 0, 0, 0, 0, 6'b110000);
    cyc("miss4", 0, 0, 0, 0, 6'b110000);
    cyc("miss5_ready", 0, 1, 0, 0, 6'b110001);
    check("miss_stall_cnt", 32'(STALL_CNT), 32'd6);
    cyc("miss_back_run", 0, 0, 0, 0, 6'b000001);
    check("miss_stall_cnt_hold", 32'(STALL_CNT), 32'd6);

    // Three-cycle flush window; load-use and miss are ignored inside it.
    apply_reset();
    cyc("fl0_mp", 0, 0, 0, 1, 6'b001100);
    cyc("fl1_lu", 0, 0, 1, 0, 6'b001100);
    cyc("fl2_imiss", 1, 0, 0, 0, 6'b001100);
    cyc("fl3_run", 0, 0, 0, 0, 6'b000000);
    check("fl_flush_cnt", 32'(FLUSH_CNT), 32'd1);
    check("fl_stall_cnt", 32'(STALL_CNT), 32'd0);

    // Second mispredict in flush cycle 2 extends the window to 4 cycles.
    apply_reset();
    cyc("ext0_mp", 0, 0, 0, 1, 6'b001100);
    cyc("ext1_mp", 0, 0, 0, 1, 6'b001100);
    cyc("ext2", 0, 0, 0, 0, 6'b001100);
    cyc("ext3", 0, 0, 0, 0, 6'b001100);
    cyc("ext4_run", 0, 0, 0, 0, 6'b000000);
    check("ext_flush_cnt", 32'(FLUSH_CNT), 32'd2);

    // Mispredict in wait cycle 2 aborts the refill and starts a flush window.
    apply_reset();
    cyc("ab0_imiss", 1, 0, 0, 0, 6'b110000);
    cyc("ab1_wait", 0, 0, 0, 0, 6'b110000);
    cyc("ab2_mp", 0, 0, 0, 1, 6'b001110);
    cyc("ab3", 0, 0, 0, 0, 6'b001100);
    cyc("ab4", 0, 0, 0, 0, 6'b001100);
    cyc("ab5_run", 0, 0, 0, 0, 6'b000000);
    check("ab_flush_cnt", 32'(FLUSH_CNT), 32'd1);
    check("ab_stall_cnt", 32'(STALL_CNT), 32'd2);

    // Load-use together with mispredict: flush only, no stall.
    apply_reset();
    cyc("lump0", 0, 0, 1, 1, 6'b001100);
    check("lump_stall_cnt", 32'(STALL_CNT), 32'd0);
    cyc("lump1", 0, 0, 0, 0, 6'b001100);
    cyc("lump2", 0, 0, 0, 0, 6'b001100);
    cyc("lump3_run", 0, 0, 0, 0, 6'b000000);
    check("lump_flush_cnt", 32'(FLUSH_CNT), 32'd1);

    // Long miss: error after 4 wait cycles, stall counter saturates at 15.
    apply_reset();
    cyc("tmo0_imiss", 1, 0, 0, 0, 6'b110000);
    for (int i = 1; i <= 18; i++) begin
      cyc($sformatf("tmo%0d", i), 0, 0, 0, 0, {5'b11000, (i >= 5)});
      if (i == 13) check("tmo_stall_cnt14", 32'(STALL_CNT), 32'd14);
    end
    check("tmo_stall_cnt_sat", 32'(STALL_CNT), 32'd15);
    cyc("tmo19_ready", 0, 1, 0, 0, 6'b110001);
    check("tmo_stall_cnt_sat2", 32'(STALL_CNT), 32'd15);
    cyc("tmo_sticky", 0, 0, 0, 0, 6'b000001);

    // Reset in the middle of a miss wait.
    apply_reset();
    cyc("rst0_imiss", 1, 0, 0, 0, 6'b110000);
    IMISS = 1'b0;
    @(negedge CLK);
    check("rst_pre", 32'(ctrl), 32'h30);
    RESET = 1'b0;
    #1;
    check("rst_drop", 32'(ctrl), 32'h0);
    check("rst_stall_cnt", 32'(STALL_CNT), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_state_run", 32'(ctrl), 32'h0);
    @(posedge CLK);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
- Front-end pipeline controller. It generates the STALL and FLUSH controls for the IF/ID and ID/EX pipeline registers from three sources: I-cache miss, load-use hazard and branch mispredict.
- It sequences the multi-cycle events: miss wait with timeout, and a multi-cycle flush window after redirect.
- It keeps saturating performance counters for stall and flush cycles.
- It sits between the hazard/branch units and the pipeline registers.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles FLUSH_IFID is asserted per mispredict (1..15).
- MISS_TIMEOUT, 255, MISS_WAIT cycles before ERR_TIMEOUT is set (1..65535).
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IMISS  in  1  I-cache reports a miss this cycle.
- IREADY  in  1  I-cache refill complete; valid only in MISS_WAIT.
- LOAD_USE  in  1  ID detected a load-use hazard; single-cycle request.
- MISPREDICT  in  1  EX resolved a branch mispredict.
- STALL_IF  out  1  freeze PC and the IF/ID register.
- STALL_ID  out  1  freeze the ID/EX register.
- FLUSH_IFID  out  1  clear the IF/ID register.
- FLUSH_IDEX  out  1  insert a bubble into ID/EX.
- IABORT  out  1  one-cycle pulse telling the I-cache to cancel an in-flight refill.
- ERR_TIMEOUT  out  1  sticky; refill exceeded MISS_TIMEOUT.
- STALL_CNT  out  CNT_W  cycles with STALL_IF=1, saturating.
- FLUSH_CNT  out  CNT_W  mispredict events accepted, saturating.

Behaviour:
- Reset (RESET=0, async):
  - state=RUN; all counters=0; ERR_TIMEOUT=0.
  - All control outputs are 0 while RESET is low.
  - A reset mid-miss or mid-flush abandons the event immediately. IABORT is not pulsed.
- Control outputs are Mealy: a combinational decode of the current state and inputs, so the pipeline registers see them in the same cycle. Counters, the state register and ERR_TIMEOUT are registered.
- Priority within a cycle: MISPREDICT > LOAD_USE > IMISS.
- State RUN:
  - MISPREDICT=1: FLUSH_IFID=1, FLUSH_IDEX=1; load flush counter with FLUSH_CYCLES-1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN. FLUSH_CNT+1.
  - Else LOAD_USE=1: STALL_IF=1, STALL_ID=0, FLUSH_IDEX=1 (bubble). Stay in RUN.
  - Else IMISS=1: STALL_IF=1, STALL_ID=1; clear the timeout counter; next state MISS_WAIT.
- State MISS_WAIT:
  - STALL_IF=1 and STALL_ID=1 every cycle.
  - IREADY=1: outputs still stall this cycle; next state RUN.
  - MISPREDICT=1, with or without IREADY: IABORT=1, FLUSH_IFID=1, FLUSH_IDEX=1, stall outputs 0; enter FLUSH as in RUN; FLUSH_CNT+1.
  - LOAD_USE is ignored in this state; the stall already covers it.
  - The timeout counter increments each cycle. When it reaches MISS_TIMEOUT, ERR_TIMEOUT is set (sticky until reset) and the wait continues.
- State FLUSH:
  - FLUSH_IFID=1 and FLUSH_IDEX=1; the flush counter decrements; return to RUN when it reaches 1.
  - A new MISPREDICT reloads the counter and increments FLUSH_CNT.
  - IMISS and LOAD_USE are ignored here.
- STALL_CNT increments on every cycle with STALL_IF=1. Both counters saturate at all-ones and do not wrap.
- Stall and flush are never both asserted on the same register in one cycle; flush wins.

Decomposition:
- Shared package: state encoding constants ST_RUN=2'd0, ST_MISS=2'd1, ST_FLUSH=2'd2, plus a `define for the default CNT_W in config.v.
- One natural sub-module, sat_counter (parameterised width, inc and clear inputs). It is instantiated twice, for STALL_CNT and FLUSH_CNT.

Test Plan:
- Reset, then idle for 10 cycles → all outputs 0 and both counters 0. Assert RESET low mid-MISS_WAIT → STALL_IF drops in the same cycle, and the state is RUN after release.
- LOAD_USE pulse for 1 cycle → STALL_IF=1, FLUSH_IDEX=1, STALL_ID=0 for exactly 1 cycle; STALL_CNT=1.
- IMISS, then IREADY 5 cycles later → STALL_IF/STALL_ID high for 6 cycles; STALL_CNT=6; then back in RUN.
- MISPREDICT with FLUSH_CYCLES=3 → FLUSH_IFID high for exactly 3 cycles; FLUSH_CNT=1. A second MISPREDICT in flush cycle 2 extends the window to 4 cycles total; FLUSH_CNT=2.
- IMISS, then MISPREDICT in wait cycle 2 → IABORT pulses for 1 cycle, the stalls drop, and a flush window follows. LOAD_USE and MISPREDICT in the same cycle in RUN → flush only, no stall.
- IMISS with MISS_TIMEOUT=4 and no IREADY for 10 cycles → ERR_TIMEOUT rises after 4 wait cycles and stays high after IREADY. With CNT_W=4 and 20 stall cycles, STALL_CNT holds at 15.
